// File: rtl/sdm_mc_pkg.sv
// Shared constants and types for the multi-channel sigma-delta modulator.
// The LFSR polynomial lives here so the channel datapath and the top agree on it.
package sdm_mc_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic en;
        logic order2;
        logic restart;
        logic ovf_clr;
    } chan_ctl_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/sdm_chan.sv
// One modulator channel: input register, two saturating integrators,
// 1-bit quantiser and the sticky overload flag.
module sdm_chan
    import sdm_mc_pkg::*;
#(
    parameter int BITS = 16,
    parameter int IW   = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  chan_ctl_t              ctl,
    input  logic                   din_valid,
    input  logic signed [BITS-1:0] din,
    input  logic signed [IW-1:0]   dith,
    output logic                   dout,
    output logic                   ovf
);
    // Two extra bits of headroom so the pre-clamp sums never wrap.
    localparam int SW = IW + 2;
    localparam logic signed [SW-1:0] FS   = {{(SW-BITS){1'b0}}, 1'b1, {(BITS-1){1'b0}}};
    localparam logic signed [SW-1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = -SMAX;

    logic signed [BITS-1:0] x_q, x_d;
    logic signed [IW-1:0]   i1_q, i1_d, i2_q, i2_d;
    logic                   dout_q, dout_d, ovf_q, ovf_d;
    logic signed [SW-1:0]   fb, s1, s2, i1s, i2s;
    logic                   c1, c2, set;

    always_comb begin
        x_d = din_valid ? din : x_q;
        fb  = dout_q ? FS : -FS;

        s1  = SW'(x_q) + SW'(dith) + SW'(i1_q) - fb;
        c1  = (s1 > SMAX) || (s1 < SMIN);
        i1s = (s1 > SMAX) ? SMAX : ((s1 < SMIN) ? SMIN : s1);

        s2  = SW'(i2_q) + i1s - fb;
        c2  = (s2 > SMAX) || (s2 < SMIN);
        i2s = (s2 > SMAX) ? SMAX : ((s2 < SMIN) ? SMIN : s2);

        i1_d   = i1s[IW-1:0];
        i2_d   = ctl.order2 ? i2s[IW-1:0] : '0;
        dout_d = ctl.order2 ? !i2s[SW-1] : !i1s[SW-1];
        set    = c1 || (ctl.order2 && c2);

        // Mute and order changes restart the loop from zero without touching the flag.
        if (!ctl.en || ctl.restart) begin
            i1_d   = '0;
            i2_d   = '0;
            dout_d = 1'b0;
            set    = 1'b0;
        end

        ovf_d = set ? 1'b1 : (ctl.ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout = dout_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/sdm_mc.sv
// Multi-channel sigma-delta DAC modulator: shared LFSR dither, order select
// register and restart detection feeding CHANNELS independent sdm_chan loops.
module sdm_mc
    import sdm_mc_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int BITS        = 16,
    parameter int GUARD       = 6,
    parameter int DITHER_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     order2,
    input  logic                     dither_en,
    input  logic                     din_valid,
    input  logic [CHANNELS*BITS-1:0] din,
    input  logic                     ovf_clr,
    output logic [CHANNELS-1:0]      dout,
    output logic [CHANNELS-1:0]      ovf
);
    localparam int IW = BITS + GUARD;

    logic [15:0] lfsr_q, lfsr_d;
    logic        order_q, order_d;
    chan_ctl_t   ctl;

    always_comb begin
        lfsr_d      = lfsr_next(lfsr_q);
        order_d     = order2;
        ctl.en      = en;
        ctl.order2  = order_q;
        ctl.restart = order2 != order_q;
        ctl.ovf_clr = ovf_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_SEED;
            order_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            order_q <= order_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [IW-1:0] dith;

        if (DITHER_BITS > 0) begin : g_dith
            // Each channel sees the same LFSR bits rotated by its index to decorrelate streams.
            localparam int R = k % DITHER_BITS;
            logic [DITHER_BITS-1:0] rot;
            always_comb begin
                rot = '0;
                for (int b = 0; b < DITHER_BITS; b++)
                    rot[(b + R) % DITHER_BITS] = lfsr_q[b];
                dith = dither_en ? {{(IW-DITHER_BITS){rot[DITHER_BITS-1]}}, rot} : '0;
            end
        end else begin : g_nodith
            assign dith = '0;
        end

        sdm_chan #(
            .BITS (BITS),
            .IW   (IW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ctl       (ctl),
            .din_valid (din_valid),
            .din       (din[k*BITS +: BITS]),
            .dith      (dith),
            .dout      (dout[k]),
            .ovf       (ovf[k])
        );
    end

endmodule

// File: tb/tb_sdm_mc.sv
// Directed bench for sdm_mc: hand-derived loop sequences, density windows,
// overload/clear behaviour, order restart, async reset and a dithered model match.
module tb_sdm_mc;

    logic        clk = 1'b0;
    logic        rst_n, en, order2, dither_en, din_valid, ovf_clr;
    logic [31:0] din, din_g;
    logic [1:0]  dout, ovf, dout_g, ovf_g;

    int n_vec = 0;
    int n_err = 0;

    // Spec-level model of the GUARD=6 instance (IW=22)
    int     m_lfsr;
    bit     m_ord;
    int     mx[2];
    longint mi1[2], mi2[2];
    bit     md[2];

    always #5 clk = ~clk;

    sdm_mc #(.CHANNELS(2), .BITS(16), .GUARD(6), .DITHER_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .order2(order2), .dither_en(dither_en),
        .din_valid(din_valid), .din(din), .ovf_clr(ovf_clr), .dout(dout), .ovf(ovf)
    );

    sdm_mc #(.CHANNELS(2), .BITS(16), .GUARD(2), .DITHER_BITS(4)) dut_g (
        .clk(clk), .rst_n(rst_n), .en(en), .order2(order2), .dither_en(dither_en),
        .din_valid(din_valid), .din(din_g), .ovf_clr(ovf_clr), .dout(dout_g), .ovf(ovf_g)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint msat(input longint v);
        longint m;
        m = (longint'(1) << 21) - 1;
        return (v > m) ? m : ((v < -m) ? -m : v);
    endfunction

    task automatic mdl_reset();
        m_lfsr = 'hACE1;
        m_ord  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0; mi1[k] = 0; mi2[k] = 0; md[k] = 1'b0;
        end
    endtask

    task automatic mdl_edge();
        longint fb, a, b, xd;
        int     r, rr, d;
        bit     rs;
        if (!rst_n) return;
        rs = (order2 != m_ord) || !en;
        for (int k = 0; k < 2; k++) begin
            r  = m_lfsr & 15;
            rr = ((r << k) | (r >> (4 - k))) & 15;
            d  = (rr >= 8) ? rr - 16 : rr;
            xd = longint'(mx[k]) + (dither_en ? longint'(d) : 64'sd0);
            fb = md[k] ? 64'sd32768 : -64'sd32768;
            a  = msat(mi1[k] + xd - fb);
            b  = m_ord ? msat(mi2[k] + a - fb) : 64'sd0;
            if (rs) begin
                mi1[k] = 0; mi2[k] = 0; md[k] = 1'b0;
            end else begin
                mi1[k] = a; mi2[k] = b; md[k] = ((m_ord ? b : a) >= 0);
            end
            if (din_valid) mx[k] = int'($signed(din[k*16 +: 16]));
        end
        m_ord  = order2;
        m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    endtask

    task automatic step();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    initial begin
        int         n0, n1, nd, mism;
        logic [1:0] seq[8];

        rst_n = 1'b0; en = 1'b0; order2 = 1'b0; dither_en = 1'b0;
        din_valid = 1'b0; din = '0; din_g = '0; ovf_clr = 1'b0;
        mdl_reset();
        #12;
        chk("rst_dout", dout, 2'b00);
        chk("rst_ovf", ovf, 2'b00);
        chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;

        // din=0, 2nd order: restart edge, then 1,1,0,1 and a 0,0,1,1 limit cycle
        order2 = 1'b1; en = 1'b1;
        step();
        chk("t1_restart", dout, 2'b00);
        seq = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t1_seq%0d", i), dout, seq[i]);
        end
        n0 = 0; n1 = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            n0 += int'(dout[0]); n1 += int'(dout[1]);
        end
        chk("t1_ones0", n0, 32);
        chk("t1_ones1", n1, 32);
        chk("t1_ovf", ovf, 2'b00);

        // +FS/2 / -FS/2 loaded during a mute edge, then two hand-traced loop edges
        en = 1'b0; din_valid = 1'b1; din = {16'hC000, 16'h4000};
        step();
        chk("t2_mute", dout, 2'b00);
        din_valid = 1'b0; en = 1'b1;
        step();
        chk("t2_c1", dout, 2'b11);
        step();
        chk("t2_c2", dout, 2'b01);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            n0 += int'(dout[0]); n1 += int'(dout[1]);
        end
        chk("t2_ones0_768", (n0 >= 766 && n0 <= 770), 1'b1);
        chk("t2_ones1_256", (n1 >= 254 && n1 <= 258), 1'b1);
        chk("t2_ovf", ovf, 2'b00);

        // GUARD=2, din=7FFF: i2 reaches 163834 > 131071 on the third loop edge
        en = 1'b0; din_valid = 1'b1; din_g = {16'h0000, 16'h7FFF};
        step();
        chk("t3_ovf_pre", ovf_g, 2'b00);
        din_valid = 1'b0; en = 1'b1;
        step();
        chk("t3_c1_dout", dout_g, 2'b11);
        chk("t3_c1_ovf", ovf_g, 2'b00);
        step();
        chk("t3_c2_ovf", ovf_g, 2'b00);
        step();
        chk("t3_c3_dout", dout_g, 2'b01);
        chk("t3_c3_ovf", ovf_g, 2'b01);
        ovf_clr = 1'b1;
        step();
        chk("t3_set_wins", ovf_g, 2'b01);
        ovf_clr = 1'b0; en = 1'b0;
        step();
        chk("t3_sticky", ovf_g, 2'b01);
        chk("t3_mute_dout", dout_g, 2'b00);
        ovf_clr = 1'b1;
        step();
        chk("t3_cleared", ovf_g, 2'b00);
        ovf_clr = 1'b0;

        // Re-arm overload, then switch to 1st order mid-run
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t4_ovf_rearm", ovf_g, 2'b01);
        order2 = 1'b0;
        step();
        chk("t4_dout0", dout, 2'b00);
        chk("t4_i1_ch0", dut.g_ch[0].u_ch.i1_q, 0);
        chk("t4_i2_ch0", dut.g_ch[0].u_ch.i2_q, 0);
        chk("t4_i1_ch1", dut.g_ch[1].u_ch.i1_q, 0);
        chk("t4_i2_ch1", dut.g_ch[1].u_ch.i2_q, 0);
        chk("t4_ovf_kept", ovf_g, 2'b01);
        seq[0] = 2'b11; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t4_o1_c%0d", i + 1), dout, seq[i]);
        end
        chk("t4_i2_held", dut.g_ch[0].u_ch.i2_q, 0);

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("t6_dout", dout, 2'b00);
        chk("t6_ovf_g", ovf_g, 2'b00);
        chk("t6_lfsr", dut.lfsr_q, 16'hACE1);
        step();
        chk("t6_lfsr_hold", dut.lfsr_q, 16'hACE1);
        rst_n = 1'b1;

        // Dithered idle channels against the model
        din = '0; dither_en = 1'b1; order2 = 1'b1; en = 1'b0;
        step();
        en = 1'b1;
        n0 = 0; n1 = 0; nd = 0; mism = 0;
        for (int i = 0; i < 4096; i++) begin
            step();
            n0 += int'(dout[0]); n1 += int'(dout[1]);
            nd += int'(dout[0] != dout[1]);
            if (dout[0] !== md[0] || dout[1] !== md[1]) mism++;
        end
        chk("t5_dens0", (n0 >= 2007 && n0 <= 2089), 1'b1);
        chk("t5_dens1", (n1 >= 2007 && n1 <= 2089), 1'b1);
        chk("t5_differ", (nd > 0), 1'b1);
        chk("t5_model", mism, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
